// File: rtl/rv32_wb_stage.sv
// rtl/rv32_wb_stage.sv - writeback stage: ALU/load merge, load queue with WAW kill, hazard reporting.
// Optional WB_BYPASS_EN: forward the output-stage write to issue instead of reporting it as pending.
module rv32_wb_stage #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int LQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_addr_lo,
  input  logic [XLEN-1:0]   ld_rdata,
  output logic              wen,
  output logic [REG_AW-1:0] wa,
  output logic [XLEN-1:0]   wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic              ra1_pend,
  output logic              ra2_pend,
  output logic [XLEN-1:0]   byp1,
  output logic [XLEN-1:0]   byp2
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LQ_DEPTH);

  logic [XLEN-1:0]   q_data_q [LQ_DEPTH];
  logic [XLEN-1:0]   q_data_d [LQ_DEPTH];
  logic [REG_AW-1:0] q_rd_q   [LQ_DEPTH];
  logic [REG_AW-1:0] q_rd_d   [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] q_live_q, q_live_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wen_q, wen_d;
  logic [REG_AW-1:0] wa_q, wa_d;
  logic [XLEN-1:0]   wd_q, wd_d;

  logic            ld_accept;
  logic [XLEN-1:0] ld_ext;
  logic            push, pop;

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                  input logic [1:0] lo,
                                                  input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] sh_b, sh_h;
    logic [7:0]      b;
    logic [15:0]     h;
    sh_b = rdata >> {lo, 3'b000};
    sh_h = rdata >> {lo[1], 4'b0000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    case (f3)
      3'b000:  load_extend = {{(XLEN-8){b[7]}}, b};
      3'b001:  load_extend = {{(XLEN-16){h[15]}}, h};
      3'b100:  load_extend = {{(XLEN-8){1'b0}}, b};
      3'b101:  load_extend = {{(XLEN-16){1'b0}}, h};
      default: load_extend = rdata;
    endcase
  endfunction

  assign ld_ready  = (count_q < DEPTH_C);
  assign ld_accept = ld_valid && ld_ready;
  assign ld_ext    = load_extend(ld_funct3, ld_addr_lo, ld_rdata);

  always_comb begin
    q_data_d = q_data_q;
    q_rd_d   = q_rd_q;
    q_live_d = q_live_q;
    head_d   = head_q;
    tail_d   = tail_q;
    wen_d    = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    push     = 1'b0;
    pop      = 1'b0;

    if (alu_valid) begin
      // ALU owns the port; rd==0 still blocks the queue this cycle.
      if (alu_rd != '0) begin
        wen_d = 1'b1;
        wa_d  = alu_rd;
        wd_d  = alu_data;
        for (int i = 0; i < LQ_DEPTH; i++)
          if (q_rd_q[i] == alu_rd) q_live_d[i] = 1'b0;
      end
      push = ld_accept && (ld_rd != '0);
    end else if (count_q != '0) begin
      pop = 1'b1;
      if (q_live_q[head_q]) begin
        wen_d = 1'b1;
        wa_d  = q_rd_q[head_q];
        wd_d  = q_data_q[head_q];
      end
      q_live_d[head_q] = 1'b0;
      head_d = head_q + PTR_W'(1);
      push   = ld_accept && (ld_rd != '0);
    end else if (ld_accept && (ld_rd != '0)) begin
      wen_d = 1'b1;
      wa_d  = ld_rd;
      wd_d  = ld_ext;
    end

    // The tail slot is free (count < depth), so the younger load lands live after any kill.
    if (push) begin
      q_data_d[tail_q] = ld_ext;
      q_rd_d[tail_q]   = ld_rd;
      q_live_d[tail_q] = 1'b1;
      tail_d = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        q_data_q[i] <= '0;
        q_rd_q[i]   <= '0;
      end
      q_live_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wen_q    <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      q_data_q <= q_data_d;
      q_rd_q   <= q_rd_d;
      q_live_q <= q_live_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wen_q    <= wen_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  assign wen = wen_q;
  assign wa  = wa_q;
  assign wd  = wd_q;

  logic p1, p2;
  always_comb begin
    p1 = 1'b0;
    p2 = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (q_live_q[i] && q_rd_q[i] == ra1) p1 = 1'b1;
      if (q_live_q[i] && q_rd_q[i] == ra2) p2 = 1'b1;
    end
`ifndef WB_BYPASS_EN
    if (wen_q && wa_q == ra1) p1 = 1'b1;
    if (wen_q && wa_q == ra2) p2 = 1'b1;
`endif
  end

  assign ra1_pend = p1 && (ra1 != '0);
  assign ra2_pend = p2 && (ra2 != '0);

`ifdef WB_BYPASS_EN
  assign byp1 = (wen_q && wa_q == ra1 && ra1 != '0) ? wd_q : '0;
  assign byp2 = (wen_q && wa_q == ra2 && ra2 != '0) ? wd_q : '0;
`else
  assign byp1 = '0;
  assign byp2 = '0;
`endif

endmodule

// File: tb/tb_rv32_wb_stage.sv
// tb/tb_rv32_wb_stage.sv - self-checking bench for rv32_wb_stage: vector table, directed sequences, random vs queue model.
module tb_rv32_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, ld_ready;
  logic [4:0]  alu_rd, ld_rd, wa, ra1, ra2;
  logic [31:0] alu_data, ld_rdata, wd, byp1, byp2;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        wen, ra1_pend, ra2_pend;

  rv32_wb_stage dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .ld_rdata(ld_rdata),
    .wen(wen), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .ra1_pend(ra1_pend), .ra2_pend(ra2_pend),
    .byp1(byp1), .byp2(byp2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: an ordered list of pending loads plus the last write.
  typedef struct { logic [4:0] rd; logic [31:0] d; bit live; } ment_t;
  ment_t       mq[$];
  bit          m_wen;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          last_acc;

  function automatic logic [31:0] m_ext(input int f3, input int lo, input logic [31:0] r);
    int unsigned b, h;
    b = (r >> (8 * lo)) & 32'hFF;
    h = (r >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      4: return b;
      5: return h;
      default: return r;
    endcase
  endfunction

  function automatic bit m_pend(input logic [4:0] ra);
    if (ra == 0) return 0;
    foreach (mq[i]) if (mq[i].live && mq[i].rd == ra) return 1;
`ifndef WB_BYPASS_EN
    if (m_wen && m_wa == ra) return 1;
`endif
    return 0;
  endfunction

  function automatic logic [31:0] m_byp(input logic [4:0] ra);
`ifdef WB_BYPASS_EN
    if (m_wen && m_wa == ra && ra != 0) return m_wd;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wen = 0; m_wa = 0; m_wd = 0;
  endtask

  // Inputs are already driven; check ready, advance one clock, check outputs.
  task automatic cycle();
    bit acc, keep;
    ment_t e;
    chk("ld_ready", ld_ready, mq.size() < 4);
    acc = ld_valid && (mq.size() < 4);
    keep = acc && ld_rd != 0;
    e.rd = ld_rd; e.d = m_ext(ld_funct3, ld_addr_lo, ld_rdata); e.live = 1;
    m_wen = 0;
    if (alu_valid) begin
      if (alu_rd != 0) begin
        foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 0;
        m_wen = 1; m_wa = alu_rd; m_wd = alu_data;
      end
      if (keep) mq.push_back(e);
    end else if (mq.size() > 0) begin
      ment_t h;
      h = mq.pop_front();
      if (h.live) begin m_wen = 1; m_wa = h.rd; m_wd = h.d; end
      if (keep) mq.push_back(e);
    end else if (keep) begin
      m_wen = 1; m_wa = e.rd; m_wd = e.d;
    end
    last_acc = acc;
    @(posedge clk); #1;
    chk("wen", wen, m_wen);
    chk("wa", wa, m_wa);
    chk("wd", wd, m_wd);
    chk("ra1_pend", ra1_pend, m_pend(ra1));
    chk("ra2_pend", ra2_pend, m_pend(ra2));
    chk("byp1", byp1, m_byp(ra1));
    chk("byp2", byp2, m_byp(ra2));
  endtask

  task automatic idle_in();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_funct3 = 3'b010; ld_addr_lo = 0; ld_rdata = 0;
  endtask

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [4:0] lrd; logic [2:0] f3; logic [1:0] lo; logic [31:0] rdat;
    logic ew; logic [4:0] ewa; logic [31:0] ewd;
  } vec_t;
  vec_t vt[13];

  initial begin
    int acc_cnt;
    vt[0]  = '{1, 5, 32'h1234,  0, 0, 3'b010, 0, 32'h0,         1, 5, 32'h0000_1234};
    vt[1]  = '{0, 0, 32'h0,     1, 2, 3'b000, 3, 32'h80FF_FF00, 1, 2, 32'hFFFF_FF80};
    vt[2]  = '{0, 0, 32'h0,     1, 3, 3'b101, 2, 32'h80FF_FF00, 1, 3, 32'h0000_80FF};
    vt[3]  = '{0, 0, 32'h0,     1, 4, 3'b001, 3, 32'h80FF_FF00, 1, 4, 32'hFFFF_80FF};
    vt[4]  = '{0, 0, 32'h0,     1, 6, 3'b100, 1, 32'h80FF_FF00, 1, 6, 32'h0000_00FF};
    vt[5]  = '{0, 0, 32'h0,     1, 6, 3'b000, 0, 32'h0000_007F, 1, 6, 32'h0000_007F};
    vt[6]  = '{0, 0, 32'h0,     1, 8, 3'b010, 2, 32'hDEAD_BEEF, 1, 8, 32'hDEAD_BEEF};
    vt[7]  = '{0, 0, 32'h0,     1, 8, 3'b011, 1, 32'h1234_5678, 1, 8, 32'h1234_5678};
    vt[8]  = '{0, 0, 32'h0,     1, 9, 3'b111, 1, 32'hCAFE_F00D, 1, 9, 32'hCAFE_F00D};
    vt[9]  = '{0, 0, 32'h0,     1, 0, 3'b000, 0, 32'h1111_1111, 0, 9, 32'hCAFE_F00D};
    vt[10] = '{1, 0, 32'h5555,  0, 0, 3'b010, 0, 32'h0,         0, 9, 32'hCAFE_F00D};
    vt[11] = '{0, 0, 32'h0,     1, 10, 3'b001, 0, 32'h1234_8001, 1, 10, 32'hFFFF_8001};
    vt[12] = '{0, 0, 32'h0,     1, 11, 3'b101, 1, 32'h0000_F00F, 1, 11, 32'h0000_F00F};

    idle_in(); ra1 = 0; ra2 = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", wen, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    chk("rst_ready", ld_ready, 1);
    rst = 0;

    for (int i = 0; i < 13; i++) begin
      alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].ad;
      ld_valid = vt[i].lv; ld_rd = vt[i].lrd; ld_funct3 = vt[i].f3;
      ld_addr_lo = vt[i].lo; ld_rdata = vt[i].rdat;
      cycle();
      chk($sformatf("vec%0d_wen", i), wen, vt[i].ew);
      chk($sformatf("vec%0d_wa", i), wa, vt[i].ewa);
      chk($sformatf("vec%0d_wd", i), wd, vt[i].ewd);
    end

    // Contention: ALU wins, load follows one cycle later.
    idle_in();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    ld_valid = 1; ld_rd = 7; ld_rdata = 32'h77; ra1 = 7;
    cycle();
    chk("cont_wa_alu", wa, 3);
    chk("cont_pend7", ra1_pend, 1);
    idle_in();
    cycle();
    chk("cont_wa_ld", wa, 7);
    chk("cont_wd_ld", wd, 32'h77);
    ra1 = 0;

    // Fill: ALU blocks for 6 cycles while loads arrive every cycle.
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_rd = 1; alu_data = i;
      ld_valid = 1; ld_rd = 5'(10 + i); ld_rdata = 32'h100 + i;
      if (ld_ready) acc_cnt++;
      cycle();
    end
    chk("fill_accepts", acc_cnt, 4);
    chk("fill_full", ld_ready, 0);
    idle_in();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("drain_wen", wen, 1);
      chk("drain_wa", wa, 10 + i);
      chk("drain_wd", wd, 32'h100 + i);
    end

    // WAW kill: queued load to x9 is superseded by a later ALU write.
    alu_valid = 1; alu_rd = 1; alu_data = 0;
    ld_valid = 1; ld_rd = 9; ld_rdata = 32'hBAD;
    cycle();
    idle_in();
    alu_valid = 1; alu_rd = 9; alu_data = 32'hA;
    cycle();
    chk("waw_wd", wd, 32'hA);
    idle_in(); ra1 = 9;
    cycle();
    chk("waw_dead_pop", wen, 0);
    chk("waw_final", wd, 32'hA);
    chk("waw_nopend", ra1_pend, 0);
    ra1 = 0;

    // Reset mid-drain.
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 1; alu_data = 0;
      ld_valid = 1; ld_rd = 5'(20 + i); ld_rdata = i;
      cycle();
    end
    idle_in();
    cycle();
    #2 rst = 1;
    #1;
    chk("mid_rst_wen", wen, 0);
    chk("mid_rst_ready", ld_ready, 1);
    model_reset();
    @(posedge clk); #1;
    chk("mid_rst_wen2", wen, 0);
    chk("mid_rst_wa", wa, 0);
    rst = 0;
    cycle();

    // Output-stage match: bypass or pend depending on build.
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44; ra2 = 4;
    cycle();
`ifdef WB_BYPASS_EN
    chk("byp2_data", byp2, 32'h44);
    chk("byp2_nopend", ra2_pend, 0);
`else
    chk("byp2_zero", byp2, 0);
    chk("ra2_stage_pend", ra2_pend, 1);
`endif

    for (int n = 0; n < 3000; n++) begin
      alu_valid  = ($urandom_range(0, 9) < 4);
      alu_rd     = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      ld_valid   = ($urandom_range(0, 1) == 1);
      ld_rd      = 5'($urandom_range(0, 7));
      ld_funct3  = 3'($urandom_range(0, 7));
      ld_addr_lo = 2'($urandom_range(0, 3));
      ld_rdata   = $urandom;
      ra1        = 5'($urandom_range(0, 7));
      ra2        = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
